// File: rtl/alu_sequencer.sv
// Issue/write-back sequencer for the 8-bit ALU: 4x8 register file + {C,S,V,Z}.
// Optional macro ALU_SEQ_CMP_EN turns op D into CMP (status-only subtract).
module alu_sequencer #(
    parameter int         NUM_REGS     = 4,
    parameter logic [3:0] RESET_STATUS = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] instr_in,
    input  logic       host_wr_en,
    input  logic [1:0] host_wr_addr,
    input  logic [7:0] host_wr_data,
    input  logic [1:0] dbg_rd_addr,
    output logic [7:0] dbg_rd_data,
    output logic [7:0] alu_a_out,
    output logic [7:0] alu_b_out,
    output logic [3:0] alu_op_out,
    output logic [3:0] alu_status_out,
    input  logic [7:0] alu_result_in,
    input  logic [3:0] alu_status_in,
    output logic [3:0] status_out,
    output logic       done
);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] regs_q [NUM_REGS];
    logic [7:0] regs_d [NUM_REGS];
    logic [3:0] status_q, status_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [3:0] op_q, op_d;
    logic [1:0] dst_q, dst_d;
    logic       wr_reg_q, wr_reg_d;
    logic       wr_stat_q, wr_stat_d;
    logic       done_q, done_d;

    logic [3:0] op_in;
    logic       op_wb;
    logic       op_cmp;

    assign op_in = instr_in[7:4];

    // Classify the incoming op: full write-back, status-only, or no-op.
    always_comb begin
        op_wb  = 1'b0;
        op_cmp = 1'b0;
        case (op_in)
            4'h0, 4'h1, 4'h4, 4'h5, 4'h6,
            4'h8, 4'h9, 4'hA, 4'hB, 4'hC: op_wb = 1'b1;
            default: op_wb = 1'b0;
        endcase
`ifdef ALU_SEQ_CMP_EN
        op_cmp = (op_in == 4'hD);
`else
        op_cmp = 1'b0;
`endif
    end

    // Next state: host loads first, so a same-cycle write-back overrides them.
    always_comb begin
        state_d   = state_q;
        regs_d    = regs_q;
        status_d  = status_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        dst_d     = dst_q;
        wr_reg_d  = wr_reg_q;
        wr_stat_d = wr_stat_q;
        done_d    = 1'b0;

        if (host_wr_en) begin
            regs_d[host_wr_addr] = host_wr_data;
        end

        unique case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    a_d       = regs_q[instr_in[3:2]];
                    b_d       = regs_q[instr_in[1:0]];
                    op_d      = op_in;
                    dst_d     = instr_in[3:2];
                    wr_reg_d  = op_wb;
                    wr_stat_d = op_wb | op_cmp;
                    if (op_cmp) begin
                        op_d = 4'h6;
                        b_d  = ~regs_q[instr_in[1:0]] + 8'd1;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (wr_reg_q) begin
                    regs_d[dst_q] = alu_result_in;
                end
                if (wr_stat_q) begin
                    status_d = alu_status_in;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
            status_q  <= RESET_STATUS;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            op_q      <= 4'h0;
            dst_q     <= 2'd0;
            wr_reg_q  <= 1'b0;
            wr_stat_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            regs_q    <= regs_d;
            status_q  <= status_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            dst_q     <= dst_d;
            wr_reg_q  <= wr_reg_d;
            wr_stat_q <= wr_stat_d;
            done_q    <= done_d;
        end
    end

    assign instr_ready    = (state_q == IDLE);
    assign dbg_rd_data    = regs_q[dbg_rd_addr];
    assign alu_a_out      = a_q;
    assign alu_b_out      = b_q;
    assign alu_op_out     = op_q;
    assign alu_status_out = status_q;
    assign status_out     = status_q;
    assign done           = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small combinational ALU model.
// Honours ALU_SEQ_CMP_EN when the design is built with it.
module tb_alu_sequencer;

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_in;
    logic       host_wr_en;
    logic [1:0] host_wr_addr;
    logic [7:0] host_wr_data;
    logic [1:0] dbg_rd_addr;
    logic [7:0] dbg_rd_data;
    logic [7:0] alu_a_out;
    logic [7:0] alu_b_out;
    logic [3:0] alu_op_out;
    logic [3:0] alu_status_out;
    logic [7:0] alu_result_in;
    logic [3:0] alu_status_in;
    logic [3:0] status_out;
    logic       done;

    int checks;
    int errors;

    alu_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_in      (instr_in),
        .host_wr_en    (host_wr_en),
        .host_wr_addr  (host_wr_addr),
        .host_wr_data  (host_wr_data),
        .dbg_rd_addr   (dbg_rd_addr),
        .dbg_rd_data   (dbg_rd_data),
        .alu_a_out     (alu_a_out),
        .alu_b_out     (alu_b_out),
        .alu_op_out    (alu_op_out),
        .alu_status_out(alu_status_out),
        .alu_result_in (alu_result_in),
        .alu_status_in (alu_status_in),
        .status_out    (status_out),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: INC, DEC, ADD, AND; anything else returns junk.
    always_comb begin
        logic [8:0] sum;
        logic       c, v;
        logic [7:0] r;
        sum = 9'd0;
        c   = 1'b0;
        v   = 1'b0;
        r   = 8'h00;
        case (alu_op_out)
            4'h4: begin
                sum = {1'b0, alu_a_out} + 9'd1;
                r   = sum[7:0];
                c   = sum[8];
                v   = (alu_a_out == 8'h7F);
            end
            4'h5: begin
                r = alu_a_out - 8'd1;
                c = (alu_a_out == 8'h00);
                v = (alu_a_out == 8'h80);
            end
            4'h6: begin
                sum = {1'b0, alu_a_out} + {1'b0, alu_b_out};
                r   = sum[7:0];
                c   = sum[8];
                v   = (alu_a_out[7] == alu_b_out[7])
                   && (r[7] != alu_a_out[7]);
            end
            4'h9: r = alu_a_out & alu_b_out;
            default: r = 8'h5A;
        endcase
        alu_result_in = r;
        if (alu_op_out inside {4'h4, 4'h5, 4'h6, 4'h9})
            alu_status_in = {c, r[7], v, (r == 8'h00)};
        else
            alu_status_in = 4'hF;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_load(input logic [1:0] a,
                             input logic [7:0] d);
        host_wr_en   = 1'b1;
        host_wr_addr = a;
        host_wr_data = d;
        step();
        host_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        if (instr_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: ready=%b done=%b want 1/0",
                     instr_ready, done);
        end
        checks++;
        if ({alu_a_out, alu_b_out, alu_op_out, status_out} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outs: a=%h b=%h op=%h st=%h want 0",
                     alu_a_out, alu_b_out, alu_op_out, status_out);
        end
        checks++;
        rst = 1'b0;
        step();
        host_load(2'd1, 8'h33);
        instr_in    = 8'h61;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        if (instr_ready !== 1'b0 || alu_b_out !== 8'h33) begin
            errors++;
            $display("FAIL reset_issue: ready=%b b=%h want 0/33",
                     instr_ready, alu_b_out);
        end
        checks++;
        #2 rst = 1'b1;
        #1;
        if (instr_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: ready=%b done=%b want 1/0",
                     instr_ready, done);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL reset_nodone: done=%b want 0", done);
            end
            checks++;
        end
        rst = 1'b0;
        step();
        if (done !== 1'b0 || status_out !== 4'h0) begin
            errors++;
            $display("FAIL reset_after: done=%b st=%h want 0/0",
                     done, status_out);
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            dbg_rd_addr = 2'(i);
            #1 rd = dbg_rd_data;
            if (rd !== 8'h00) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h want 00", i, rd);
            end
            checks++;
        end
    endtask

    task automatic test_add();
        host_load(2'd1, 8'h7F);
        host_load(2'd2, 8'h01);
        instr_in    = 8'h66;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        if (alu_op_out !== 4'h6 || alu_a_out !== 8'h7F
            || alu_b_out !== 8'h01) begin
            errors++;
            $display("FAIL add_e0: op=%h a=%h b=%h want 6/7f/01",
                     alu_op_out, alu_a_out, alu_b_out);
        end
        checks++;
        if (instr_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL add_issue: ready=%b done=%b want 0/0",
                     instr_ready, done);
        end
        checks++;
        step();
        dbg_rd_addr = 2'd1;
        #1;
        if (dbg_rd_data !== 8'h80 || status_out !== 4'b0110) begin
            errors++;
            $display("FAIL add_wb: r1=%h st=%b want 80/0110",
                     dbg_rd_data, status_out);
        end
        checks++;
        if (done !== 1'b1 || instr_ready !== 1'b1
            || alu_status_out !== 4'b0110) begin
            errors++;
            $display("FAIL add_done: done=%b ready=%b ast=%b want 1/1/0110",
                     done, instr_ready, alu_status_out);
        end
        checks++;
        step();
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL add_pulse: done=%b want 0", done);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int low;
        low = 0;
        dbg_rd_addr = 2'd0;
        instr_in    = 8'h50;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        if (!instr_ready) low++;
        step();
        if (dbg_rd_data !== 8'hFF || status_out !== 4'b1100
            || done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_dec: r0=%h st=%b done=%b want ff/1100/1",
                     dbg_rd_data, status_out, done);
        end
        checks++;
        if (!instr_ready) low++;
        instr_in    = 8'h40;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        if (!instr_ready) low++;
        if (alu_a_out !== 8'hFF || alu_op_out !== 4'h4
            || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_e0: a=%h op=%h done=%b want ff/4/0",
                     alu_a_out, alu_op_out, done);
        end
        checks++;
        step();
        if (!instr_ready) low++;
        if (dbg_rd_data !== 8'h00 || status_out !== 4'b1001
            || done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_inc: r0=%h st=%b done=%b want 00/1001/1",
                     dbg_rd_data, status_out, done);
        end
        checks++;
        if (low !== 2) begin
            errors++;
            $display("FAIL b2b_ready: low cycles=%0d want 2", low);
        end
        checks++;
        step();
    endtask

    task automatic test_undefined();
        dbg_rd_addr = 2'd1;
        instr_in    = 8'h25;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        if (dbg_rd_data !== 8'h80 || status_out !== 4'b1001
            || done !== 1'b1) begin
            errors++;
            $display("FAIL undef: r1=%h st=%b done=%b want 80/1001/1",
                     dbg_rd_data, status_out, done);
        end
        checks++;
        step();
    endtask

    task automatic test_collision();
        host_load(2'd2, 8'hF0);
        host_load(2'd3, 8'h3C);
        instr_in    = 8'h9B;
        instr_valid = 1'b1;
        step();
        instr_valid  = 1'b0;
        host_wr_en   = 1'b1;
        host_wr_addr = 2'd2;
        host_wr_data = 8'hAA;
        step();
        host_wr_en  = 1'b0;
        dbg_rd_addr = 2'd2;
        #1;
        if (dbg_rd_data !== 8'h30 || status_out !== 4'b0000
            || done !== 1'b1) begin
            errors++;
            $display("FAIL coll_wb: r2=%h st=%b done=%b want 30/0000/1",
                     dbg_rd_data, status_out, done);
        end
        checks++;
        instr_valid = 1'b1;
        step();
        instr_valid  = 1'b0;
        host_wr_en   = 1'b1;
        host_wr_addr = 2'd0;
        host_wr_data = 8'h77;
        step();
        host_wr_en  = 1'b0;
        dbg_rd_addr = 2'd0;
        #1;
        if (dbg_rd_data !== 8'h77) begin
            errors++;
            $display("FAIL coll_other: r0=%h want 77", dbg_rd_data);
        end
        checks++;
        dbg_rd_addr = 2'd2;
        #1;
        if (dbg_rd_data !== 8'h30) begin
            errors++;
            $display("FAIL coll_r2: r2=%h want 30", dbg_rd_data);
        end
        checks++;
        step();
    endtask

    task automatic test_op_d();
        host_load(2'd0, 8'h05);
        host_load(2'd1, 8'h05);
        instr_in    = 8'hD1;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
`ifdef ALU_SEQ_CMP_EN
        if (alu_op_out !== 4'h6 || alu_b_out !== 8'hFB) begin
            errors++;
            $display("FAIL cmp_e0: op=%h b=%h want 6/fb",
                     alu_op_out, alu_b_out);
        end
        checks++;
`else
        if (alu_op_out !== 4'hD || alu_b_out !== 8'h05) begin
            errors++;
            $display("FAIL opd_e0: op=%h b=%h want d/05",
                     alu_op_out, alu_b_out);
        end
        checks++;
`endif
        step();
        dbg_rd_addr = 2'd0;
        #1;
`ifdef ALU_SEQ_CMP_EN
        if (dbg_rd_data !== 8'h05 || status_out !== 4'b1001
            || done !== 1'b1) begin
            errors++;
            $display("FAIL cmp_wb: r0=%h st=%b done=%b want 05/1001/1",
                     dbg_rd_data, status_out, done);
        end
        checks++;
`else
        if (dbg_rd_data !== 8'h05 || status_out !== 4'b0000
            || done !== 1'b1) begin
            errors++;
            $display("FAIL opd_wb: r0=%h st=%b done=%b want 05/0000/1",
                     dbg_rd_data, status_out, done);
        end
        checks++;
`endif
        step();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        instr_valid  = 1'b0;
        instr_in     = 8'h00;
        host_wr_en   = 1'b0;
        host_wr_addr = 2'd0;
        host_wr_data = 8'h00;
        dbg_rd_addr  = 2'd0;
        step();
        test_reset();
        test_add();
        test_back_to_back();
        test_undefined();
        test_collision();
        test_op_d();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Issuing and write-back side of the 8-bit ALU in the tiny CPU.
- Owns a 4-entry x 8-bit register file and the 4-bit status register {C,S,V,Z}.
- Accepts one-byte ALU instructions over a valid/ready handshake, drives operands, op and current status to the ALU, then writes the result and status back.
- Sits between the instruction decoder/host and the combinational ALU instance.

Parameters:
NUM_REGS, 4, register-file depth; fixed at 4 (2-bit register fields in the instruction).
RESET_STATUS, 4'h0, status register value after reset.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
instr_valid  input  1  instruction byte present
instr_ready  output  1  sequencer can accept an instruction; high only in IDLE
instr_in  input  8  [7:4] alu op, [3:2] destination / A-source register, [1:0] B-source register
host_wr_en  input  1  host register load strobe
host_wr_addr  input  2  host load target register
host_wr_data  input  8  host load data
dbg_rd_addr  input  2  debug read address
dbg_rd_data  output  8  combinational read of the register file
alu_a_out  output  8  ALU operand A (registered)
alu_b_out  output  8  ALU operand B (registered)
alu_op_out  output  4  ALU op code (registered)
alu_status_out  output  4  current status register value, {C,S,V,Z}
alu_result_in  input  8  ALU result
alu_status_in  input  4  ALU status result, {C,S,V,Z}
status_out  output  4  status register value; same as alu_status_out
done  output  1  one-cycle pulse after each instruction retires

Behaviour:
Reset (asynchronous, immediate):
- Registers r0..r3 = 0; status = RESET_STATUS.
- alu_a_out, alu_b_out and alu_op_out = 0; done = 0; state = IDLE, so instr_ready = 1.
- Reset asserted mid-instruction aborts it: no write-back, no done pulse.

FSM states are IDLE and ISSUE.
- IDLE: instr_ready = 1. On the edge where instr_valid && instr_ready (E0):
  - alu_a_out <= r[instr[3:2]], alu_b_out <= r[instr[1:0]], alu_op_out <= instr[7:4].
  - Latch the destination index; go to ISSUE.
- ISSUE: instr_ready = 0. The ALU is combinational, so the result is valid this cycle. On the next edge (E1):
  - Write-back op: r[dst] <= alu_result_in; status <= alu_status_in.
  - done <= 1 for exactly one cycle; state <= IDLE.
- Timing: latency is 2 edges from handshake to write-back. Peak throughput is 1 instruction per 2 cycles. A new handshake is possible in the cycle done is high.

Op classes:
- Write-back ops: 0,1,4,5,6,8,9,A,B,C.
- Undefined ops (2,3,7,D,E,F without the optional feature): take the same 2 cycles and pulse done. No register write, status unchanged.
- Unary ops (0,1,4,5,8,C) still drive alu_b_out from the B field; the ALU ignores it.

Read/write ordering:
- Operand read at E0 sees the register value before any write on that same edge.
- Host write at E1 to the same register as the write-back: the write-back wins and the host write is dropped.
- Host writes to other registers, or in any other cycle, always take effect.
- dbg_rd_data is a combinational read of register contents after the last edge.
- alu_status_out reflects the status register, so INC/ADD etc. see the pre-instruction C/V.

Optional Feature:
Macro ALU_SEQ_CMP_EN.
- Defined: op D is CMP. At E0, alu_op_out <= 4'h6 and alu_b_out <= (~r[B] + 1) mod 256. At E1 only status is written; the register file is unchanged; done pulses.
- Not defined: op D is undefined, i.e. a no-op that still pulses done.

Test Plan:
1. Reset: assert rst mid-ISSUE -> done never pulses; registers/status read 0; instr_ready = 1 immediately.
2. ADD: host loads r1 = 8'h7F, r2 = 8'h01; issue 8'h66 (ADD r1,r2) -> alu_op_out = 6 and alu_a/alu_b = 7F/01 after E0; after E1 r1 = 8'h80, status = 4'b0110 (C=0,S=1,V=1,Z=0), one done pulse.
3. Back-to-back: issue DEC r0 (8'h50, r0 = 0) then, on the done cycle, INC r0 (8'h40) -> r0 = FF, then r0 = 00; final status C=1, Z=1; instr_ready low exactly one cycle per instruction.
4. Undefined op 8'h25 with status = 4'b1001 -> no register change, status stays 4'b1001, done pulses.
5. Collision: during ISSUE of 8'h9B (AND r2,r3), host writes r2 = 8'hAA at E1 -> r2 holds the AND result. A host write to r0 in the same cycle lands.
6. With ALU_SEQ_CMP_EN: r0 = 8'h05, r1 = 8'h05, issue 8'hD1 -> alu_b_out = 8'hFB; r0 stays 05; Z = 1, C = 1.
